// File: rtl/serial_pkg.sv
// serial_pkg: definitions shared by the serial link transmit and receive ends.
//   - FSM state encoding (2-bit, legacy-compatible localparams)
//   - default frame width (DEF_DBIT) and bit period in clocks (DEF_DVSR)
package serial_pkg;

    localparam logic [1:0] IDLE  = 2'b00;
    localparam logic [1:0] START = 2'b01;
    localparam logic [1:0] DATA  = 2'b10;
    localparam logic [1:0] STOP  = 2'b11;

    localparam int DEF_DBIT = 8;
    localparam int DEF_DVSR = 16;

endpackage

// File: rtl/serial_bit_timer.sv
// bit_timer: bit-period counter for the serial link.
//   clk, reset : clock, synchronous active-high reset
//   clr        : synchronous clear (highest priority after reset)
//   run        : count enable; the counter clears itself after DVSR-1
//   cnt        : current count, $clog2(DVSR) bits
//   tc         : terminal count, high while cnt == DVSR-1
module bit_timer #(
    parameter int DVSR = 16,
    localparam int CW = (DVSR > 1) ? $clog2(DVSR) : 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clr,
    input  logic          run,
    output logic [CW-1:0] cnt,
    output logic          tc
);

    logic [CW-1:0] cnt_q, cnt_d;

    assign cnt = cnt_q;
    assign tc  = (cnt_q == CW'(DVSR - 1));

    always_comb begin
        cnt_d = cnt_q;
        if (clr || (run && tc))
            cnt_d = '0;
        else if (run)
            cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

endmodule

// File: rtl/serial_tx.sv
// serial_tx: frames a DBIT-wide word as start bit, data LSB-first, stop bit.
//   clk, reset   : clock, synchronous active-high reset
//   tx_start     : request to send din, honoured only in IDLE
//   din          : word to send, captured on the accepting edge
//   tx_busy      : registered, high from accept until return to IDLE
//   tx_done_tick : one-cycle pulse in the last cycle of the stop bit
//   tx           : registered serial line, idles high
module serial_tx
    import serial_pkg::*;
#(
    parameter int DBIT = DEF_DBIT,
    parameter int DVSR = DEF_DVSR
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            tx_start,
    input  logic [DBIT-1:0] din,
    output logic            tx_busy,
    output logic            tx_done_tick,
    output logic            tx
);

    localparam int BW = (DBIT > 1) ? $clog2(DBIT) : 1;
    localparam int CW = (DVSR > 1) ? $clog2(DVSR) : 1;

    logic [1:0]      state_q, state_d;
    logic [BW-1:0]   bit_q, bit_d;
    logic [DBIT-1:0] shift_q, shift_d;
    logic            tx_q, tx_d;
    logic            busy_q, busy_d;

    logic [CW-1:0]   tick_cnt;
    logic            tick_tc;

    // Held clear in IDLE, so every frame starts its start bit at count 0.
    bit_timer #(.DVSR(DVSR)) u_bit_timer (
        .clk   (clk),
        .reset (reset),
        .clr   (state_q == IDLE),
        .run   (state_q != IDLE),
        .cnt   (tick_cnt),
        .tc    (tick_tc)
    );

    always_comb begin
        state_d = state_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        tx_d    = tx_q;
        busy_d  = busy_q;
        case (state_q)
            IDLE: begin
                tx_d = 1'b1;
                if (tx_start) begin
                    shift_d = din;
                    tx_d    = 1'b0;
                    busy_d  = 1'b1;
                    state_d = START;
                end
            end
            START: begin
                if (tick_tc) begin
                    bit_d   = '0;
                    tx_d    = shift_q[0];
                    state_d = DATA;
                end
            end
            DATA: begin
                if (tick_tc) begin
                    shift_d = shift_q >> 1;
                    if (bit_q == BW'(DBIT - 1)) begin
                        tx_d    = 1'b1;
                        state_d = STOP;
                    end else begin
                        bit_d = bit_q + 1'b1;
                        // Next LSB is bit 1 of the pre-shift word.
                        tx_d  = shift_q[1];
                    end
                end
            end
            STOP: begin
                if (tick_tc) begin
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            bit_q   <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
            busy_q  <= busy_d;
        end
    end

    assign tx           = tx_q;
    assign tx_busy      = busy_q;
    assign tx_done_tick = (state_q == STOP) && tick_tc;

endmodule

// File: tb/tb_serial_tx.sv
module tb_serial_tx;

    logic       clk = 1'b0;
    logic       reset = 1'b1;

    logic       start_a = 1'b0;
    logic [7:0] din_a = '0;
    logic       busy_a, done_a, tx_a;

    logic       start_b = 1'b0;
    logic [6:0] din_b = '0;
    logic       busy_b, done_b, tx_b;

    int checks = 0;
    int passes = 0;
    logic exp_q[$];

    always #5 clk = ~clk;

    serial_tx #(.DBIT(8), .DVSR(4)) dut_a (
        .clk          (clk),
        .reset        (reset),
        .tx_start     (start_a),
        .din          (din_a),
        .tx_busy      (busy_a),
        .tx_done_tick (done_a),
        .tx           (tx_a)
    );

    serial_tx #(.DBIT(7), .DVSR(2)) dut_b (
        .clk          (clk),
        .reset        (reset),
        .tx_start     (start_b),
        .din          (din_b),
        .tx_busy      (busy_b),
        .tx_done_tick (done_b),
        .tx           (tx_b)
    );

    // Expected line levels, one entry per cycle, starting the cycle after accept.
    task automatic push_frame(input logic [7:0] d, input int nb, input int dv);
        for (int i = 0; i < dv; i++) exp_q.push_back(1'b0);
        for (int b = 0; b < nb; b++)
            for (int i = 0; i < dv; i++) exp_q.push_back(d[b]);
        for (int i = 0; i < dv; i++) exp_q.push_back(1'b1);
    endtask

    task automatic test_reset();
        reset = 1'b1; start_a = 1'b1; start_b = 1'b1; din_a = 8'hA5; din_b = 7'h55;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checks++; if (tx_a !== 1'b1) $display("FAIL reset_tx c=%0d: got %b want 1", c, tx_a); else passes++;
            checks++; if (busy_a !== 1'b0) $display("FAIL reset_busy c=%0d: got %b want 0", c, busy_a); else passes++;
            checks++; if (done_a !== 1'b0) $display("FAIL reset_done c=%0d: got %b want 0", c, done_a); else passes++;
            checks++; if (tx_b !== 1'b1 || busy_b !== 1'b0) $display("FAIL reset_b c=%0d: got tx=%b busy=%b want 1/0", c, tx_b, busy_b); else passes++;
        end
        reset = 1'b0; start_a = 1'b0; start_b = 1'b0;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            checks++; if (tx_a !== 1'b1 || busy_a !== 1'b0) $display("FAIL reset_noframe: got tx=%b busy=%b want 1/0", tx_a, busy_a); else passes++;
        end
    endtask

    // One DBIT=8/DVSR=4 frame; optional tx_start+din=FF pulse at cycle 'inject'.
    task automatic run_frame_a(input string name, input logic [7:0] d, input int inject);
        logic e;
        @(negedge clk); start_a = 1'b1; din_a = d;
        @(posedge clk); #1 start_a = 1'b0; din_a = ~d;
        push_frame(d, 8, 4);
        for (int c = 1; c <= 41; c++) begin
            @(negedge clk);
            e = (c <= 40) ? exp_q.pop_front() : 1'b1;
            checks++; if (tx_a !== e) $display("FAIL %s_tx c=%0d: got %b want %b", name, c, tx_a, e); else passes++;
            checks++; if (done_a !== (c == 40)) $display("FAIL %s_done c=%0d: got %b want %b", name, c, done_a, c == 40); else passes++;
            checks++; if (busy_a !== (c <= 40)) $display("FAIL %s_busy c=%0d: got %b want %b", name, c, busy_a, c <= 40); else passes++;
            if (inject != 0) begin
                if (c == inject) begin start_a = 1'b1; din_a = 8'hFF; end
                else if (c == inject + 1) start_a = 1'b0;
            end
        end
        start_a = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            checks++; if (tx_a !== 1'b1 || busy_a !== 1'b0 || done_a !== 1'b0)
                $display("FAIL %s_idle: got tx=%b busy=%b done=%b want 1/0/0", name, tx_a, busy_a, done_a);
            else passes++;
        end
    endtask

    task automatic test_single();
        run_frame_a("single", 8'hA5, 0);
    endtask

    task automatic test_ignored_start();
        run_frame_a("ign_data", 8'h3C, 15);
        run_frame_a("ign_done", 8'h3C, 40);
    endtask

    task automatic test_reset_mid();
        logic e;
        @(negedge clk); start_a = 1'b1; din_a = 8'h00;
        @(posedge clk); #1 start_a = 1'b0;
        push_frame(8'h00, 8, 4);
        for (int c = 1; c <= 18; c++) begin
            @(negedge clk);
            e = exp_q.pop_front();
            checks++; if (tx_a !== e) $display("FAIL rmid_tx c=%0d: got %b want %b", c, tx_a, e); else passes++;
        end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        exp_q.delete();
        checks++; if (tx_a !== 1'b1) $display("FAIL rmid_tx_after: got %b want 1", tx_a); else passes++;
        checks++; if (busy_a !== 1'b0) $display("FAIL rmid_busy_after: got %b want 0", busy_a); else passes++;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            checks++; if (done_a !== 1'b0 || tx_a !== 1'b1) $display("FAIL rmid_quiet c=%0d: got done=%b tx=%b want 0/1", c, done_a, tx_a); else passes++;
        end
        run_frame_a("post_reset", 8'h96, 0);
    endtask

    task automatic test_back_to_back();
        logic e;
        int dones = 0;
        @(negedge clk); start_a = 1'b1; din_a = 8'h81;
        @(posedge clk); #1;
        push_frame(8'h81, 8, 4);
        exp_q.push_back(1'b1);
        push_frame(8'h81, 8, 4);
        for (int c = 1; c <= 81; c++) begin
            @(negedge clk);
            e = exp_q.pop_front();
            if (done_a === 1'b1) dones++;
            checks++; if (tx_a !== e) $display("FAIL b2b_tx c=%0d: got %b want %b", c, tx_a, e); else passes++;
            checks++; if (done_a !== (c == 40 || c == 81)) $display("FAIL b2b_done c=%0d: got %b", c, done_a); else passes++;
            checks++; if (busy_a !== (c != 41)) $display("FAIL b2b_busy c=%0d: got %b want %b", c, busy_a, c != 41); else passes++;
            if (c == 81) start_a = 1'b0;
        end
        checks++; if (dones != 2) $display("FAIL b2b_done_count: got %0d want 2", dones); else passes++;
        @(negedge clk);
        checks++; if (tx_a !== 1'b1 || busy_a !== 1'b0) $display("FAIL b2b_end: got tx=%b busy=%b want 1/0", tx_a, busy_a); else passes++;
    endtask

    task automatic test_sweep();
        logic e;
        @(negedge clk); start_b = 1'b1; din_b = 7'h55;
        @(posedge clk); #1 start_b = 1'b0; din_b = 7'h00;
        push_frame(8'h55, 7, 2);
        for (int c = 1; c <= 19; c++) begin
            @(negedge clk);
            e = (c <= 18) ? exp_q.pop_front() : 1'b1;
            checks++; if (tx_b !== e) $display("FAIL sweep_tx c=%0d: got %b want %b", c, tx_b, e); else passes++;
            checks++; if (done_b !== (c == 18)) $display("FAIL sweep_done c=%0d: got %b want %b", c, done_b, c == 18); else passes++;
            checks++; if (busy_b !== (c <= 18)) $display("FAIL sweep_busy c=%0d: got %b want %b", c, busy_b, c <= 18); else passes++;
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_ignored_start();
        test_reset_mid();
        test_back_to_back();
        test_sweep();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/serial_tx.md
# serial_tx

Parallel-in, serial-out transmit register that frames a DBIT-wide word as start bit, data LSB-first, and stop bit on a single line. It is the transmit end of the team's serial link. A bit-period counter times each bit. A start/busy/done handshake connects it to the upstream logic that produces words.

## Interface
- DBIT, 8, number of data bits per frame (≥ 2)
- DVSR, 16, clock cycles per bit period (≥ 2)
- clk  input  1  system clock, all state changes on rising edge
- reset  input  1  synchronous, active-high reset
- tx_start  input  1  request to send din; sampled only in IDLE
- din  input  DBIT  word to transmit; captured on the accepting edge
- tx_busy  output  1  high from the accepting edge until return to IDLE
- tx_done_tick  output  1  one-cycle pulse in the final cycle of the stop bit
- tx  output  1  serial line, registered, idles high

## Operation
- Reset values: state IDLE, tx = 1, tx_busy = 0, tx_done_tick = 0, bit counter 0, tick counter 0, shift register 0.
- Reset has priority over every other event and may occur mid-frame. The next edge returns the block to the reset values, and the partial frame is abandoned.
- **IDLE**
  - tx = 1.
  - When tx_start = 1 at an edge: load din into the shift register, tick counter ← 0, tx ← 0, tx_busy ← 1, go to START.
- **START**
  - tx = 0 for DVSR cycles.
  - When tick counter = DVSR−1: tick counter ← 0, bit counter ← 0, tx ← shift[0], go to DATA.
- **DATA**
  - When tick counter = DVSR−1: shift register ← shift right by 1, tick counter ← 0.
  - If bit counter = DBIT−1: tx ← 1 and go to STOP. Otherwise bit counter +1 and tx ← next LSB.
- **STOP**
  - tx = 1 for DVSR cycles.
  - When tick counter = DVSR−1: tx_done_tick = 1 for that cycle. At the next edge: go to IDLE, tx_busy ← 0.
- tx_start while not in IDLE is ignored, including the tx_done_tick cycle. The frame in progress and the latched word are unaffected.
- din changes after the accepting edge have no effect on the frame.
- Counter widths:
  - tick counter is $clog2(DVSR) bits and wraps only via the explicit clear at DVSR−1.
  - bit counter is $clog2(DBIT) bits.
- Encoding is unsigned; there is no parity.

## Timing
- Accepting edge k: tx goes low in the cycle after edge k.
- Bit n of the data is on tx during cycles k+1+(n+1)·DVSR … k+(n+2)·DVSR.
- Frame length is (DBIT+2)·DVSR cycles, starting from the cycle after edge k.
- tx_done_tick is high in cycle k+(DBIT+2)·DVSR. tx_busy is low from the next cycle onward.
- Minimum spacing between accepting edges is (DBIT+2)·DVSR+1 cycles, which includes one mandatory IDLE cycle.
- tx never glitches, because it is driven only from a flop.
- tx_done_tick is decoded combinationally from the state and tick counter and is stable within the cycle.

## Structure
- Shared package serial_pkg holds:
  - state encoding localparams IDLE = 2'b00, START = 2'b01, DATA = 2'b10, STOP = 2'b11
  - default DBIT and DVSR values
- The receive end uses the same package.
- One sub-module, bit_timer:
  - parameterized DVSR counter with synchronous clear and terminal-count output
  - instantiated once; reusable by the receiver
- The top level holds the FSM, bit counter, shift register and tx flop.
- Separate state/next-state logic; registered outputs only for tx and tx_busy.

## Test plan
- **Reset:** assert reset for 3 cycles while tx_start = 1 → tx = 1, tx_busy = 0, tx_done_tick = 0 throughout; no frame starts.
- **Single frame:** DVSR = 4, DBIT = 8; pulse tx_start with din = 8'hA5 at edge k.
  - tx over 40 cycles: 0 ×4, then 1,0,1,0,0,1,0,1 each ×4, then 1 ×4.
  - tx_done_tick high only at k+40; tx_busy low from k+41.
- **Ignored start:** during the DATA phase of 8'h3C, pulse tx_start with din = 8'hFF → frame still carries 8'h3C; no second frame follows.
- **Reset mid-frame:** assert reset at bit 3 of 8'h00 → tx = 1 and tx_busy = 0 after the edge; no tx_done_tick; a new tx_start after release sends a full, correct frame.
- **Back-to-back:** hold tx_start = 1 continuously with din = 8'h81 → frames separated by exactly 1 idle-high cycle; tx_done_tick once per frame.
- **Parameter sweep:** DBIT = 7, DVSR = 2, din = 7'h55 → 18-cycle frame with correct LSB-first pattern.
